// File: rtl/ahb_tg_pkg.sv
// Shared encodings and the address-derived data pattern for the AHB traffic generator.
package ahb_tg_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    typedef enum logic [1:0] {
        MODE_WRITE = 2'd0,
        MODE_READ  = 2'd1,
        MODE_WR_RB = 2'd2,
        MODE_RSVD  = 2'd3
    } mode_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_DATA,
        ST_GAP,
        ST_DONE
    } state_e;

    // Seed XOR address, both zero-extended to 64 bits and then masked down to
    // the bus width, so callers of any width just truncate the result.
    function automatic logic [63:0] pattern(input logic [63:0] seed,
                                            input logic [63:0] addr,
                                            input int unsigned width);
        logic [63:0] mask;
        mask = (width >= 64) ? '1 : ((64'd1 << width) - 64'd1);
        return (seed ^ addr) & mask;
    endfunction

endpackage

// File: rtl/ahb_apb_traffic_gen.sv
// AHB-Lite master that issues single NONSEQ transfers from base_addr in write,
// read-check or write-then-readback mode and counts read mismatches / ERRORs.
module ahb_apb_traffic_gen
    import ahb_tg_pkg::*;
#(
    parameter int          ADDR_W = 32,
    parameter int          DATA_W = 32,
    parameter int          CNT_W  = 8,
    parameter int          GAP    = 0,
    parameter logic [31:0] SEED   = 32'hA5A5_0000
) (
    input  logic              hclk,
    input  logic              hreset_n,
    input  logic              start,
    input  logic [1:0]        mode,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [CNT_W-1:0]  num_trans,
    output logic [ADDR_W-1:0] haddr,
    output logic [1:0]        htrans,
    output logic              hwrite,
    output logic [2:0]        hsize,
    output logic [DATA_W-1:0] hwdata,
    input  logic [DATA_W-1:0] hrdata,
    input  logic              hready,
    input  logic              hresp,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [CNT_W-1:0]  err_cnt
);

    localparam int                BYTES     = DATA_W / 8;
    localparam logic [2:0]        HSIZE     = 3'($clog2(BYTES));
    localparam logic [ADDR_W-1:0] ADDR_STEP = ADDR_W'(BYTES);
    localparam logic [3:0]        GAP_LOAD  = (GAP > 0) ? 4'(GAP - 1) : 4'd0;
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

    state_e            state, state_nxt;
    mode_e             mode_q;
    logic [ADDR_W-1:0] base_q;
    logic [CNT_W-1:0]  num_q;
    logic [CNT_W-1:0]  idx;
    logic              rd_pass;
    logic [3:0]        gap_cnt;
    logic [DATA_W-1:0] pat;
    logic              xfer_done, last_xfer, more_pass, mismatch;
    logic [CNT_W-1:0]  err_nxt;
    logic [1:0]        htrans_nxt;
    logic              busy_nxt, done_nxt;

    assign hsize     = HSIZE;
    // haddr is held through the data phase, so it names the pattern both when
    // loading write data and when checking read data.
    assign pat       = DATA_W'(pattern(64'(SEED), 64'(haddr), DATA_W));
    assign xfer_done = (state == ST_DATA) && hready;
    assign last_xfer = (idx == num_q - CNT_ONE);
    assign more_pass = (mode_q == MODE_WR_RB) && !rd_pass;
    assign mismatch  = !hwrite && (hrdata != pat);

    // Saturating error count for the transfer completing this cycle.
    always_comb begin
        err_nxt = err_cnt;
        if (xfer_done && (hresp || mismatch) && (err_cnt != CNT_MAX))
            err_nxt = err_cnt + CNT_ONE;
    end

    // State register.
    always_ff @(posedge hclk or negedge hreset_n) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples pre-edge values regardless of block ordering.
        if (!hreset_n) state <= ST_IDLE;
        else           state <= state_nxt;
    end

    // Next-state logic.
    always_comb begin
        // NOTE: default first so no path through the case leaves state_nxt
        // unassigned, which would infer a latch.
        state_nxt = state;
        case (state)
            ST_IDLE: if (start) state_nxt = (num_trans == '0) ? ST_DONE : ST_ADDR;
            ST_ADDR: if (hready) state_nxt = ST_DATA;
            ST_DATA: if (hready) begin
                if (last_xfer && !more_pass) state_nxt = ST_DONE;
                else if (GAP > 0)            state_nxt = ST_GAP;
                else                         state_nxt = ST_ADDR;
            end
            ST_GAP:  if (gap_cnt == '0) state_nxt = ST_ADDR;
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Output decode from the next state; registered below so outputs are glitch-free.
    always_comb begin
        htrans_nxt = (state_nxt == ST_ADDR) ? HTRANS_NONSEQ : HTRANS_IDLE;
        busy_nxt   = state_nxt inside {ST_ADDR, ST_DATA, ST_GAP};
        done_nxt   = (state_nxt == ST_DONE);
    end

    // Bus outputs, transfer index, pass/error bookkeeping and gap counter.
    always_ff @(posedge hclk or negedge hreset_n) begin
        if (!hreset_n) begin
            haddr   <= '0;
            htrans  <= HTRANS_IDLE;
            hwrite  <= 1'b0;
            hwdata  <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            pass    <= 1'b0;
            err_cnt <= '0;
            mode_q  <= MODE_WRITE;
            base_q  <= '0;
            num_q   <= '0;
            idx     <= '0;
            rd_pass <= 1'b0;
            gap_cnt <= '0;
        end else begin
            htrans <= htrans_nxt;
            busy   <= busy_nxt;
            done   <= done_nxt;

            if (state == ST_IDLE && start) begin
                err_cnt <= '0;
                if (num_trans == '0) begin
                    pass <= 1'b1;
                end else begin
                    mode_q  <= (mode_e'(mode) == MODE_RSVD) ? MODE_WRITE : mode_e'(mode);
                    base_q  <= base_addr;
                    num_q   <= num_trans;
                    idx     <= '0;
                    rd_pass <= 1'b0;
                    haddr   <= base_addr;
                    hwrite  <= (mode_e'(mode) != MODE_READ);
                end
            end

            if (state == ST_ADDR && hready && hwrite)
                hwdata <= pat;

            // Address advances only as the data phase retires, keeping haddr
            // stable for the read compare.
            if (xfer_done) begin
                err_cnt <= err_nxt;
                if (last_xfer) begin
                    if (more_pass) begin
                        idx     <= '0;
                        rd_pass <= 1'b1;
                        haddr   <= base_q;
                        hwrite  <= 1'b0;
                    end else begin
                        pass <= (err_nxt == '0);
                    end
                end else begin
                    idx   <= idx + CNT_ONE;
                    haddr <= haddr + ADDR_STEP;
                end
            end

            if (state_nxt == ST_GAP && state != ST_GAP)
                gap_cnt <= GAP_LOAD;
            else if (state == ST_GAP && gap_cnt != '0)
                gap_cnt <= gap_cnt - 4'd1;
        end
    end

endmodule

// File: tb/tb_ahb_apb_traffic_gen.sv
// Self-checking bench: table of runs against a memory slave with random stalls,
// plus hand-written reset, gap and saturation sequences.
module tb_ahb_apb_traffic_gen;

    typedef struct {
        int          mode;
        logic [31:0] base;
        int          n;
        int          stall;
        bit          corrupt_en;
        logic [31:0] corrupt_addr;
        int          err_xfer;
        int          restart;
        int          exp_err;
        bit          exp_pass;
        int          exp_cyc;
    } vec_t;

    typedef struct {
        logic [31:0] addr;
        logic        wr;
        logic [31:0] data;
    } xfer_t;

    logic        hclk = 1'b0;
    logic        hreset_n = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  mode = '0;
    logic [31:0] base_addr = '0;
    logic [7:0]  num_trans = '0;
    logic [31:0] haddr, hwdata, hrdata;
    logic [1:0]  htrans;
    logic        hwrite, hready, hresp, busy, done, pass;
    logic [2:0]  hsize;
    logic [7:0]  err_cnt;

    logic        start_g = 1'b0;
    logic [1:0]  mode_g = '0;
    logic [31:0] base_g = '0;
    logic [2:0]  num_g = '0;
    logic [31:0] haddr_g, hwdata_g, hrdata_g;
    logic [1:0]  htrans_g;
    logic        hwrite_g, hready_g, hresp_g, busy_g, done_g, pass_g;
    logic [2:0]  hsize_g;
    logic [2:0]  err_cnt_g;

    int vectors = 0;
    int miscompares = 0;

    // Slave configuration, written only by the main sequence.
    int          stall_max = 0;
    bit          corrupt_en = 0;
    logic [31:0] corrupt_addr = '0;
    int          err_target = 0;
    bit          force_stall = 0;
    bit          err_all_g = 0;

    // Slave-owned state and observations.
    int          xfer_no = 0;
    int          hold_errs = 0;
    logic [31:0] mem [logic [31:0]];
    xfer_t       xlog [$];
    bit          s_dph, s_dph_wr, s_dph_err, s_err_phase, s_a_seen, s_a_wr, prev_ns_g;
    logic [31:0] s_dph_addr, s_a_addr;
    int          s_stall_left, s_a_stall;

    ahb_apb_traffic_gen #(.ADDR_W(32), .DATA_W(32), .CNT_W(8), .GAP(0)) u_dut (
        .hclk(hclk), .hreset_n(hreset_n), .start(start), .mode(mode),
        .base_addr(base_addr), .num_trans(num_trans), .haddr(haddr), .htrans(htrans),
        .hwrite(hwrite), .hsize(hsize), .hwdata(hwdata), .hrdata(hrdata),
        .hready(hready), .hresp(hresp), .busy(busy), .done(done), .pass(pass),
        .err_cnt(err_cnt)
    );

    ahb_apb_traffic_gen #(.ADDR_W(32), .DATA_W(32), .CNT_W(3), .GAP(2)) u_dut_gap (
        .hclk(hclk), .hreset_n(hreset_n), .start(start_g), .mode(mode_g),
        .base_addr(base_g), .num_trans(num_g), .haddr(haddr_g), .htrans(htrans_g),
        .hwrite(hwrite_g), .hsize(hsize_g), .hwdata(hwdata_g), .hrdata(hrdata_g),
        .hready(hready_g), .hresp(hresp_g), .busy(busy_g), .done(done_g), .pass(pass_g),
        .err_cnt(err_cnt_g)
    );

    initial forever #5 hclk = ~hclk;

    function automatic logic [31:0] ref_pat(input logic [31:0] a);
        return 32'hA5A5_0000 ^ a;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(int m, logic [31:0] b, int n, int st, bit ce, logic [31:0] ca,
                                int ex, int rs, int ee, bit ep, int ec);
        vec_t v;
        v.mode = m; v.base = b; v.n = n; v.stall = st; v.corrupt_en = ce; v.corrupt_addr = ca;
        v.err_xfer = ex; v.restart = rs; v.exp_err = ee; v.exp_pass = ep; v.exp_cyc = ec;
        return v;
    endfunction

    // Memory slave on the main DUT; decides hready/hresp/hrdata at each falling edge.
    task automatic slave_step();
        hresp = 1'b0;
        if (!hreset_n) begin
            s_dph = 0; s_a_seen = 0; hready = 1'b1;
        end else if (s_dph) begin
            if (htrans != 2'b00) hold_errs++;
            if (s_dph_wr && hwdata != ref_pat(s_dph_addr)) hold_errs++;
            if (s_dph_err && !s_err_phase) begin
                hready = 1'b0; hresp = 1'b1; s_err_phase = 1;
            end else if (force_stall || s_stall_left > 0) begin
                hready = 1'b0;
                if (s_stall_left > 0) s_stall_left--;
            end else begin
                hready = 1'b1; hresp = s_dph_err;
                if (s_dph_wr) mem[s_dph_addr] = hwdata;
                else begin
                    hrdata = mem.exists(s_dph_addr) ? mem[s_dph_addr] : ref_pat(s_dph_addr);
                    if (corrupt_en && s_dph_addr == corrupt_addr) hrdata = ~hrdata;
                end
                xlog.push_back('{s_dph_addr, s_dph_wr, hwdata});
                s_dph = 0;
            end
        end else if (htrans == 2'b10) begin
            if (!s_a_seen) begin
                s_a_seen = 1; s_a_addr = haddr; s_a_wr = hwrite;
                s_a_stall = (stall_max > 0) ? int'($urandom_range(stall_max, 0)) : 0;
            end else if (haddr != s_a_addr || hwrite != s_a_wr) begin
                hold_errs++;
            end
            if (s_a_stall > 0) begin
                hready = 1'b0; s_a_stall--;
            end else begin
                hready = 1'b1; s_a_seen = 0; s_dph = 1;
                s_dph_addr = haddr; s_dph_wr = hwrite; xfer_no++;
                s_dph_err = (xfer_no == err_target); s_err_phase = 0;
                s_stall_left = (stall_max > 0 && !s_dph_err) ? int'($urandom_range(stall_max, 0)) : 0;
            end
        end else begin
            if (s_a_seen) begin hold_errs++; s_a_seen = 0; end
            hready = 1'b1;
        end
    endtask

    initial begin
        hready = 1'b1; hresp = 1'b0; hrdata = '0; s_dph = 0; s_a_seen = 0;
        forever begin
            @(negedge hclk);
            slave_step();
        end
    end

    // Always-ready slave for the gap instance; optionally answers every transfer with ERROR.
    initial begin
        hready_g = 1'b1; hresp_g = 1'b0; hrdata_g = '0; prev_ns_g = 0;
        forever begin
            @(negedge hclk);
            hresp_g = err_all_g && prev_ns_g;
            prev_ns_g = (htrans_g == 2'b10);
        end
    end

    // Launch one run, then compare timing, status and the observed transfer list
    // against the list the specification's rules produce.
    task automatic run_vec(input vec_t v);
        int cyc, ls, h0, ei, passes;
        bit seen, wexp;
        logic [31:0] a;
        stall_max = v.stall; corrupt_en = v.corrupt_en; corrupt_addr = v.corrupt_addr;
        err_target = (v.err_xfer != 0) ? xfer_no + v.err_xfer : 0;
        ls = xlog.size(); h0 = hold_errs;
        mode = 2'(v.mode); base_addr = v.base; num_trans = 8'(v.n); start = 1'b1;
        seen = 0; cyc = 0;
        while (!seen && cyc < 2000) begin
            @(negedge hclk);
            cyc++;
            start = 1'b0;
            if (cyc == v.restart) begin start = 1'b1; mode = 2'd1; num_trans = 8'd1; end
            if (cyc == 1) check("busy_cycle1", busy, v.n != 0);
            if (done) seen = 1;
        end
        start = 1'b0;
        check("done_seen", seen, 1);
        if (v.exp_cyc != 0) check("done_cycle", cyc, v.exp_cyc);
        check("err_cnt", err_cnt, v.exp_err);
        check("pass", pass, v.exp_pass);
        check("busy_at_done", busy, 0);
        check("hold_violations", hold_errs - h0, 0);
        passes = (v.mode == 2) ? 2 : 1;
        check("xfer_count", xlog.size() - ls, passes * v.n);
        ei = ls;
        for (int p = 0; p < passes; p++) begin
            for (int k = 0; k < v.n; k++) begin
                a = v.base + 32'(k * 4);
                wexp = !(v.mode == 1 || (v.mode == 2 && p == 1));
                if (ei < xlog.size()) begin
                    check("xfer_addr", xlog[ei].addr, a);
                    check("xfer_write", xlog[ei].wr, wexp);
                    if (wexp) check("xfer_wdata", xlog[ei].data, ref_pat(a));
                end
                ei++;
            end
        end
        @(negedge hclk);
        check("done_pulse", done, 0);
    endtask

    initial begin
        vec_t tab [12];
        int cyc;
        bit seen;
        int ns_cyc [$];

        tab[0]  = mk(0, 32'h100, 4, 0, 0, 0, 0, 0, 0, 1, 9);
        tab[1]  = mk(1, 32'h100, 4, 0, 1, 32'h108, 0, 0, 1, 0, 9);
        tab[2]  = mk(0, 32'h200, 4, 0, 0, 0, 2, 0, 1, 0, 10);
        tab[3]  = mk(0, 32'h300, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        tab[4]  = mk(2, 32'h3F0, 3, 0, 0, 0, 0, 0, 0, 1, 13);
        tab[5]  = mk(2, 32'hFFFF_FFF8, 4, 0, 0, 0, 0, 0, 0, 1, 17);
        tab[6]  = mk(3, 32'h40, 2, 0, 0, 0, 0, 0, 0, 1, 5);
        tab[7]  = mk(2, 32'h1000, 16, 3, 0, 0, 0, 0, 0, 1, 0);
        tab[8]  = mk(0, 32'h500, 4, 0, 0, 0, 0, 3, 0, 1, 9);
        for (int i = 9; i < 12; i++)
            tab[i] = mk(int'($urandom_range(3, 0)), $urandom() & 32'hFFFF_FFFC,
                        int'($urandom_range(12, 1)), int'($urandom_range(3, 0)),
                        0, 0, 0, 0, 0, 1, 0);

        // Reset values while reset is held.
        repeat (3) @(negedge hclk);
        check("rst_haddr", haddr, 0);
        check("rst_htrans", htrans, 0);
        check("rst_hwrite", hwrite, 0);
        check("rst_hsize", hsize, 2);
        check("rst_hwdata", hwdata, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_pass", pass, 0);
        check("rst_err_cnt", err_cnt, 0);
        check("rst_htrans_gap", htrans_g, 0);
        hreset_n = 1'b1;
        @(negedge hclk);

        for (int i = 0; i < 12; i++) run_vec(tab[i]);

        // Reset asserted while a read data phase is stalled.
        stall_max = 0; corrupt_en = 0; err_target = 0; force_stall = 1;
        mode = 2'd1; base_addr = 32'h600; num_trans = 8'd4; start = 1'b1;
        @(negedge hclk); start = 1'b0;
        @(negedge hclk);
        @(negedge hclk);
        check("stall_busy", busy, 1);
        check("stall_htrans", htrans, 0);
        check("stall_haddr", haddr, 32'h600);
        #2 hreset_n = 1'b0;
        #1;
        check("arst_busy", busy, 0);
        check("arst_htrans", htrans, 0);
        check("arst_haddr", haddr, 0);
        check("arst_hwrite", hwrite, 0);
        force_stall = 0;
        @(negedge hclk);
        @(negedge hclk); hreset_n = 1'b1;
        @(negedge hclk);
        check("post_rst_busy", busy, 0);
        check("post_rst_htrans", htrans, 0);
        run_vec(mk(0, 32'h700, 2, 0, 0, 0, 0, 0, 0, 1, 5));

        // GAP = 2 instance: NONSEQ every 4 cycles, done after 2N + 2(N-1) + 1 cycles.
        err_all_g = 0; mode_g = 2'd0; base_g = 32'h800; num_g = 3'd3; start_g = 1'b1;
        seen = 0; cyc = 0;
        while (!seen && cyc < 200) begin
            @(negedge hclk);
            cyc++;
            start_g = 1'b0;
            if (htrans_g == 2'b10) ns_cyc.push_back(cyc);
            if (done_g) seen = 1;
        end
        check("gap_done_seen", seen, 1);
        check("gap_done_cycle", cyc, 11);
        check("gap_nonseq_count", ns_cyc.size(), 3);
        for (int i = 1; i < ns_cyc.size(); i++)
            check("gap_spacing", ns_cyc[i] - ns_cyc[i-1], 4);
        check("gap_pass", pass_g, 1);
        @(negedge hclk);

        // Every transfer answered with ERROR: 12 errors saturate a 3-bit counter.
        err_all_g = 1; mode_g = 2'd2; num_g = 3'd6; start_g = 1'b1;
        seen = 0; cyc = 0;
        while (!seen && cyc < 400) begin
            @(negedge hclk);
            cyc++;
            start_g = 1'b0;
            if (done_g) seen = 1;
        end
        check("sat_done_seen", seen, 1);
        check("sat_err_cnt", err_cnt_g, 7);
        check("sat_pass", pass_g, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
